// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and the MEM stage (D).
// One access at a time: IDLE -> ACCESS (strobes held MEM_LATENCY cycles) -> RESP (valid pulse).
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_readFlag,
  output logic              mem_writeFlag,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              busy
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              owner_d_q, owner_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              grant_d;

  // Data wins unless it has already taken MAX_STREAK contended grants in a row.
  assign grant_d = d_req & (~if_req | (streak_q < SW'(MAX_STREAK)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_d_d  = owner_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          owner_d_d  = grant_d;
          we_d       = grant_d & d_we;
          addr_d     = grant_d ? d_addr : if_addr;
          wdata_d    = grant_d ? d_wdata : '0;
          d_ready_d  = grant_d;
          if_ready_d = ~grant_d;
          rd_d       = ~(grant_d & d_we);
          wr_d       = grant_d & d_we;
          cnt_d      = CW'(MEM_LATENCY - 1);
          state_d    = ACCESS;
          if (!grant_d) begin
            streak_d = '0;
          end else if (if_req && streak_q != SW'(MAX_STREAK)) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (owner_d_q) begin
            d_rdata_d = we_q ? '0 : mem_rdata_in;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_in;
            if_valid_d = 1'b1;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_d_q  <= owner_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  assign if_ready      = if_ready_q;
  assign if_valid      = if_valid_q;
  assign if_rdata      = if_rdata_q;
  assign d_ready       = d_ready_q;
  assign d_valid       = d_valid_q;
  assign d_rdata       = d_rdata_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_readFlag  = rd_q;
  assign mem_writeFlag = wr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LATENCY=1 instance (dut) and a MEM_LATENCY=3 instance (dut3),
// with per-instance response scoreboards checked whenever a valid pulse appears.
module tb_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  logic clk, rst;
  int   vectors = 0;
  int   errs    = 0;
  int   cyc     = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  // Instance with MEM_LATENCY=1
  logic        if_req, if_ready, if_valid, d_req, d_we, d_ready, d_valid;
  logic        mem_readFlag, mem_writeFlag, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata_in;

  // Instance with MEM_LATENCY=3
  logic        b_if_req, b_if_ready, b_if_valid, b_d_req, b_d_we, b_d_ready, b_d_valid;
  logic        b_rd, b_wr, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata_in;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata_in   = memf(mem_addr);
  assign b_mem_rdata_in = 32'hC0DE0000 + 32'(cyc);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_readFlag(mem_readFlag),
    .mem_writeFlag(mem_writeFlag), .mem_rdata_in(mem_rdata_in), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_valid(b_if_valid),
    .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_readFlag(b_rd),
    .mem_writeFlag(b_wr), .mem_rdata_in(b_mem_rdata_in), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t e1, e3;
  always @(negedge clk) begin
    if (!rst) begin
      if ((if_ready && d_ready) || (if_valid && d_valid) || (mem_readFlag && mem_writeFlag)) begin
        errs++;
        $display("FAIL exclusive_l1: got rdy=%b%b vld=%b%b strb=%b%b required at most one of each",
                 if_ready, d_ready, if_valid, d_valid, mem_readFlag, mem_writeFlag);
      end
      if (if_valid || d_valid) begin
        vectors++;
        if (sb1.size() == 0) begin
          errs++;
          $display("FAIL unexpected_valid_l1: got if_valid=%b d_valid=%b required none", if_valid, d_valid);
        end else begin
          e1 = sb1.pop_front();
          if (d_valid !== e1.is_d || (d_valid ? d_rdata : if_rdata) !== e1.data) begin
            errs++;
            $display("FAIL resp_l1: got is_d=%b data=%h required is_d=%b data=%h",
                     d_valid, d_valid ? d_rdata : if_rdata, e1.is_d, e1.data);
          end
        end
      end
      if (b_if_valid || b_d_valid) begin
        vectors++;
        if (sb3.size() == 0) begin
          errs++;
          $display("FAIL unexpected_valid_l3: got if_valid=%b d_valid=%b required none", b_if_valid, b_d_valid);
        end else begin
          e3 = sb3.pop_front();
          if (b_d_valid !== e3.is_d || (b_d_valid ? b_d_rdata : b_if_rdata) !== e3.data) begin
            errs++;
            $display("FAIL resp_l3: got is_d=%b data=%h required is_d=%b data=%h",
                     b_d_valid, b_d_valid ? b_d_rdata : b_if_rdata, e3.is_d, e3.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    tick(); tick();
    vectors++;
    if ({if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, mem_addr, mem_wdata,
         mem_readFlag, mem_writeFlag, busy} !== '0) begin
      errs++; $display("FAIL reset_l1: got nonzero outputs required all 0 (busy=%b)", busy);
    end
    vectors++;
    if ({b_if_ready, b_if_valid, b_if_rdata, b_d_ready, b_d_valid, b_d_rdata, b_mem_addr,
         b_mem_wdata, b_rd, b_wr, b_busy} !== '0) begin
      errs++; $display("FAIL reset_l3: got nonzero outputs required all 0 (busy=%b)", b_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h40;
    sb1.push_back('{1'b0, 32'hDEADBEEF});
    tick();
    vectors++;
    if ({if_ready, d_ready, mem_readFlag, mem_writeFlag, busy} !== 5'b10101) begin
      errs++; $display("FAIL if_read_t1: got rdy/drdy/rd/wr/busy=%b required 10101",
                       {if_ready, d_ready, mem_readFlag, mem_writeFlag, busy});
    end
    vectors++;
    if (mem_addr !== 32'h40) begin
      errs++; $display("FAIL if_read_addr: got %h required 00000040", mem_addr);
    end
    if_req = 0;
    tick();
    vectors++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF || mem_readFlag !== 1'b0) begin
      errs++; $display("FAIL if_read_t2: got valid=%b rdata=%h rd=%b required 1 deadbeef 0",
                       if_valid, if_rdata, mem_readFlag);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || if_valid !== 1'b0) begin
      errs++; $display("FAIL if_read_t3: got busy=%b valid=%b required 0 0", busy, if_valid);
    end
  endtask

  task automatic test_d_write_read();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
    sb1.push_back('{1'b1, 32'h0});
    tick();
    vectors++;
    if ({d_ready, if_ready, mem_writeFlag, mem_readFlag} !== 4'b1010 ||
        mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
      errs++; $display("FAIL d_write_t1: got rdy/irdy/wr/rd=%b addr=%h wdata=%h required 1010 100 12345678",
                       {d_ready, if_ready, mem_writeFlag, mem_readFlag}, mem_addr, mem_wdata);
    end
    d_req = 0; d_we = 0; d_addr = 32'h200; d_wdata = 32'hFFFFFFFF;
    tick();
    vectors++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h0 || mem_writeFlag !== 1'b0 || if_valid !== 1'b0) begin
      errs++; $display("FAIL d_write_t2: got valid=%b rdata=%h wr=%b required 1 0 0",
                       d_valid, d_rdata, mem_writeFlag);
    end
    tick();
    d_req = 1;
    sb1.push_back('{1'b1, memf(32'h200)});
    tick();
    vectors++;
    if (d_ready !== 1'b1 || mem_readFlag !== 1'b1 || mem_writeFlag !== 1'b0) begin
      errs++; $display("FAIL d_read_t1: got rdy=%b rd=%b wr=%b required 1 1 0",
                       d_ready, mem_readFlag, mem_writeFlag);
    end
    d_req = 0;
    tick();
    vectors++;
    if (d_valid !== 1'b1 || d_rdata !== memf(32'h200)) begin
      errs++; $display("FAIL d_read_t2: got valid=%b rdata=%h required 1 %h", d_valid, d_rdata, memf(32'h200));
    end
    tick();
  endtask

  task automatic test_contention();
    int waited;
    bit got;
    rst = 1;
    if_req = 1; if_addr = 32'h84; d_req = 1; d_we = 0; d_addr = 32'h300;
    sb1.push_back('{1'b1, memf(32'h300)});
    sb1.push_back('{1'b0, memf(32'h84)});
    tick();
    rst = 0;
    tick();
    vectors++;
    if (d_ready !== 1'b1 || if_ready !== 1'b0) begin
      errs++; $display("FAIL contention_first: got d_ready=%b if_ready=%b required 1 0", d_ready, if_ready);
    end
    d_req = 0;
    waited = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(); waited++;
      if (if_ready) got = 1;
    end
    vectors++;
    if (!got || waited != 3) begin
      errs++; $display("FAIL contention_if_grant: got granted=%0b after %0d cycles required 1 after 3", got, waited);
    end
    if_req = 0;
    tick(); tick();
  endtask

  task automatic test_starvation();
    int waited;
    bit got, exp_d;
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h310;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) sb1.push_back('{1'b0, memf(32'h80)});
      else            sb1.push_back('{1'b1, memf(32'h310)});
    end
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5 != 4);
      waited = 0; got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
        tick(); waited++;
        if (if_ready || d_ready) got = 1;
      end
      vectors++;
      if (!got || d_ready !== exp_d || if_ready !== !exp_d) begin
        errs++; $display("FAIL starve_grant%0d: got d_ready=%b if_ready=%b required d=%b", k, d_ready, if_ready, exp_d);
      end
      if (k > 0) begin
        vectors++;
        if (waited != 3) begin
          errs++; $display("FAIL starve_gap%0d: got %0d cycles required 3", k, waited);
        end
      end
      if (k == 9) begin
        if_req = 0; d_req = 0;
      end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_latency3();
    int t0, strobes;
    t0 = cyc;
    b_if_req = 1; b_if_addr = 32'h44;
    sb3.push_back('{1'b0, 32'hC0DE0000 + 32'(t0 + 3)});
    strobes = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (b_rd) strobes++;
      if (i == 1) begin
        vectors++;
        if (b_if_ready !== 1'b1) begin
          errs++; $display("FAIL l3_ready: got %b required 1", b_if_ready);
        end
        b_if_req = 0; b_if_addr = 32'hFFFFFFFF;
      end
      if (i == 3) begin
        vectors++;
        if (b_mem_addr !== 32'h44 || b_rd !== 1'b1 || b_if_valid !== 1'b0) begin
          errs++; $display("FAIL l3_hold: got addr=%h rd=%b valid=%b required 44 1 0", b_mem_addr, b_rd, b_if_valid);
        end
      end
      if (i == 4) begin
        vectors++;
        if (b_if_valid !== 1'b1 || b_if_rdata !== 32'hC0DE0000 + 32'(t0 + 3)) begin
          errs++; $display("FAIL l3_valid: got valid=%b rdata=%h required 1 %h",
                           b_if_valid, b_if_rdata, 32'hC0DE0000 + 32'(t0 + 3));
        end
      end
    end
    vectors++;
    if (strobes != 3) begin
      errs++; $display("FAIL l3_strobe_cycles: got %0d required 3", strobes);
    end
  endtask

  task automatic test_reset_abort();
    d_req = 1; d_we = 0; d_addr = 32'h240;
    tick();
    vectors++;
    if (d_ready !== 1'b1 || mem_readFlag !== 1'b1) begin
      errs++; $display("FAIL abort_grant: got d_ready=%b rd=%b required 1 1", d_ready, mem_readFlag);
    end
    d_req = 0; rst = 1;
    tick();
    vectors++;
    if ({if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, mem_addr, mem_wdata,
         mem_readFlag, mem_writeFlag, busy} !== '0) begin
      errs++; $display("FAIL abort_outputs: got valid=%b rd=%b busy=%b required all 0", d_valid, mem_readFlag, busy);
    end
    rst = 0;
    tick(); tick(); tick();
    if_req = 1; if_addr = 32'h60;
    sb1.push_back('{1'b0, memf(32'h60)});
    tick();
    vectors++;
    if (if_ready !== 1'b1) begin
      errs++; $display("FAIL abort_fresh_ready: got %b required 1", if_ready);
    end
    if_req = 0;
    tick();
    vectors++;
    if (if_valid !== 1'b1 || if_rdata !== memf(32'h60)) begin
      errs++; $display("FAIL abort_fresh_valid: got valid=%b rdata=%h required 1 %h", if_valid, if_rdata, memf(32'h60));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_d_write_read();
    test_contention();
    test_starvation();
    test_latency3();
    test_reset_abort();
    tick(); tick(); tick();
    vectors++;
    if (sb1.size() != 0 || sb3.size() != 0) begin
      errs++; $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", sb1.size(), sb3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
